// File: rtl/ws2812_chain_driver.sv
// ws2812_chain_driver: continuously refreshes a 4-LED WS2812-style daisy
// chain. Each frame snapshots the four RGB inputs, serialises 96 bits as NRZ
// pulses (MSB first, LED1 first), then holds the line low for a latch gap.
module ws2812_chain_driver #(
  parameter int T0H_CYCLES = 20,
  parameter int T1H_CYCLES = 40,
  parameter int BIT_CYCLES = 63,
  parameter int GAP_CYCLES = 15000,
  parameter int GRB_ORDER  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:23] led1_rgb,
  input  logic [0:23] led2_rgb,
  input  logic [0:23] led3_rgb,
  input  logic [0:23] led4_rgb,
  output logic        dout,
  output logic        frame_start,
  output logic        busy
);

  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] T0H_C    = CYC_W'(T0H_CYCLES);
  localparam logic [CYC_W-1:0] T1H_C    = CYC_W'(T1H_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [6:0]       BIT_LAST = 7'd95;

  localparam logic [1:0] ST_GAP   = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [6:0]       bit_idx_q, bit_idx_d;
  logic [95:0]      sr_q, sr_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             fs_q, fs_d;

  // Inputs carry R in the leftmost byte; the wire order puts G first.
  function automatic logic [23:0] led_order(input logic [0:23] c);
    if (GRB_ORDER != 0) led_order = {c[8:15], c[0:7], c[16:23]};
    else                led_order = c;
  endfunction

  // Next-state logic. dout is computed for the *next* cycle so the pin is a
  // flop output and the first high cycle of every bit lands on its boundary.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    cyc_d     = cyc_q;
    bit_idx_d = bit_idx_q;
    sr_d      = sr_q;
    dout_d    = 1'b0;
    case (state_q)
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_LATCH;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_LATCH: begin
        sr_d      = {led_order(led1_rgb), led_order(led2_rgb),
                     led_order(led3_rgb), led_order(led4_rgb)};
        cyc_d     = '0;
        bit_idx_d = '0;
        state_d   = ST_SEND;
        dout_d    = 1'b1;  // every bit starts high, whatever its value
      end
      ST_SEND: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            state_d = ST_GAP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            sr_d      = {sr_q[94:0], 1'b0};
            dout_d    = 1'b1;
          end
        end else begin
          cyc_d  = cyc_q + 1'b1;
          dout_d = (cyc_d < (sr_q[95] ? T1H_C : T0H_C));
        end
      end
      default: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
    endcase
    busy_d = (state_d == ST_SEND);
    fs_d   = (state_d == ST_LATCH);
  end

  // State and output registers; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_GAP;
      gap_cnt_q <= '0;
      cyc_q     <= '0;
      bit_idx_q <= '0;
      sr_q      <= '0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      cyc_q     <= cyc_d;
      bit_idx_q <= bit_idx_d;
      sr_q      <= sr_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      fs_q      <= fs_d;
    end
  end

  assign dout        = dout_q;
  assign busy        = busy_q;
  assign frame_start = fs_q;

endmodule
